div_issue_ctrl: RTL

- Initiator-side controller that sits in the EXE stage and drives the 32-bit iterative divider.
- Accepts a divide or modulo micro-op from EXE and launches the divider with a one-cycle start pulse.
- Stalls EXE until the divider signals completion, then holds the selected quotient or remainder until the downstream stage accepts it.
- Handles pipeline flush while a divide is in flight. The divider cannot be aborted, so the controller drains it.

---
 rtl/div_issue_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// EXE-stage initiator for the 32-bit iterative divider.
// Launches one divide, stalls EXE, holds the result and drains the divider on flush.
module div_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             div_clk,
  input  logic             reset,
  input  logic             es_valid,
  input  logic [1:0]       es_op,
  input  logic [WIDTH-1:0] es_src1,
  input  logic [WIDTH-1:0] es_src2,
  input  logic             es_flush,
  input  logic             out_ready,
  output logic             div_stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             div,
  output logic             div_signed,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             complete
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             sel;
  logic             sel_n;
  logic             div_n;
  logic             sgn_n;
  logic [WIDTH-1:0] x_n;
  logic [WIDTH-1:0] y_n;
  logic             rv_n;
  logic [WIDTH-1:0] rd_n;

  always_ff @(posedge div_clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sel        <= 1'b0;
      div        <= 1'b0;
      div_signed <= 1'b0;
      x          <= '0;
      y          <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      div        <= div_n;
      div_signed <= sgn_n;
      x          <= x_n;
      y          <= y_n;
      res_valid  <= rv_n;
      res_data   <= rd_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    div_n   = 1'b0;
    sgn_n   = div_signed;
    x_n     = x;
    y_n     = y;
    rv_n    = res_valid;
    rd_n    = res_data;
    unique case (state)
      S_IDLE: begin
        if (es_valid && !es_flush) begin
          x_n     = es_src1;
          y_n     = es_src2;
          sgn_n   = !es_op[1];
          sel_n   = es_op[0];
          div_n   = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // the start pulse is already out, so a flush here must drain
        state_n = es_flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (complete) begin
          if (es_flush) begin
            state_n = S_IDLE;
          end else begin
            rd_n    = sel ? r : s;
            rv_n    = 1'b1;
            state_n = S_HOLD;
          end
        end else if (es_flush) begin
          state_n = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (es_flush || out_ready) begin
          rv_n    = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (complete) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign div_stall = !reset && es_valid &&
                     !(state == S_HOLD && out_ready && !es_flush);

endmodule
